command_word_sequencer: RTL and testbench
=========================================

COMMAND_WORD_SEQUENCER -- requirements
Module: command_word_sequencer

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset: ports clock and reset_n.
REQ-002 clock  input  1  system clock; all state updates on rising edge.
REQ-003 reset_n  input  1  synchronous active-low reset.
REQ-004 chip_select_n  input  1  active-low device select, synchronous to clock.
REQ-005 write_enable_n  input  1  active-low CPU write strobe, synchronous to clock.
REQ-006 address  input  1  A0 of CPU bus.
REQ-007 data_bus_in  input  8  CPU write data.
REQ-008 internal_data_bus  output  8  latched write data, held until next write event.
REQ-009 write_initial_command_word_1 .. write_initial_command_word_4  output  1 each  one-cycle ICW strobes.
REQ-010 write_operation_control_word_1_registers, write_operation_control_word_2, write_operation_control_word_3  output  1 each  one-cycle OCW strobes.
REQ-011 in_initialization  output  1  high from ICW1 until sequence completes.
REQ-012 cascade_mode  output  1  inverse of ICW1 bit D1 (SNGL), latched at ICW1.
REQ-013 icw4_required  output  1  ICW1 bit D0 (IC4), latched at ICW1.

Function
REQ-014 Write capture: every cycle with chip_select_n=0 and write_enable_n=0, address and data_bus_in SHALL be captured (last value wins).
REQ-015 Write event: first cycle N with write_enable_n=1 following at least one capture cycle; chip_select_n state at N is irrelevant.
REQ-016 On event at cycle N, internal_data_bus SHALL update and exactly one strobe SHALL be high during cycle N+1 only; state updates at N+1.
REQ-017 States: UNINIT, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY.
REQ-018 address=0 with data bit D4=1 SHALL be ICW1 in any state: strobe ICW1, latch SNGL/IC4, go WAIT_ICW2.
REQ-019 WAIT_ICW2, address=1: strobe ICW2; next WAIT_ICW3 if cascade_mode, else WAIT_ICW4 if icw4_required, else READY.
REQ-020 WAIT_ICW3, address=1: strobe ICW3; next WAIT_ICW4 if icw4_required, else READY.
REQ-021 WAIT_ICW4, address=1: strobe ICW4; next READY.
REQ-022 In WAIT_ICW2/3/4, address=0 with D4=0 SHALL be ignored (no strobe, no state change); internal_data_bus still updates.
REQ-023 READY: address=1 -> OCW1 strobe; address=0, D4=0, D3=0 -> OCW2 strobe; address=0, D4=0, D3=1 -> OCW3 strobe; state stays READY.
REQ-024 UNINIT: all writes except ICW1 SHALL be ignored (no strobe).
REQ-025 in_initialization SHALL be high exactly in WAIT_ICW2/3/4.
REQ-026 Back-to-back events (one-cycle write_enable_n high gap) SHALL each produce their strobe; no event SHALL be lost.
REQ-027 At most one strobe output SHALL be high in any cycle.

Reset
REQ-028 reset_n=0 SHALL force state UNINIT, all strobes 0, internal_data_bus 8'h00, cascade_mode 0, icw4_required 0, in_initialization 0, capture cleared.
REQ-029 A write in progress when reset asserts SHALL produce no strobe after reset releases unless write_enable_n is re-asserted low afterwards.
REQ-030 ICW1 received mid-sequence or in READY SHALL restart initialization; previous SNGL/IC4 SHALL be overwritten.

Structure
REQ-031 Shared package SHALL hold the state enum and bit-position constants (A0 select, D4 ICW1 flag, D3 OCW3 flag, D1 SNGL, D0 IC4).
REQ-032 One sub-module write_event_detector SHALL implement REQ-014/015, outputting event pulse, captured address and captured data.

Verification
REQ-033 ICW1=8'h13 (SNGL=1, IC4=1), ICW2=8'h20, ICW4=8'h01 -> strobes ICW1, ICW2, ICW4 in order, no ICW3, in_initialization low after ICW4, cascade_mode=0.
REQ-034 ICW1=8'h10, ICW2, ICW3=8'h04 -> ICW3 strobed, READY after ICW3 with no ICW4, cascade_mode=1, icw4_required=0.
REQ-035 READY: write A0=1 data 8'h0F -> OCW1 strobe one cycle after write_enable_n rises, internal_data_bus=8'h0F; A0=0 8'h20 -> OCW2; A0=0 8'h08 -> OCW3.
REQ-036 After reset, A0=1 8'hFF and A0=0 8'h20 -> no strobes; then ICW1 -> ICW1 strobe.
REQ-037 ICW1 8'h11, ICW2, then ICW1 8'h12 -> sequence restarts to WAIT_ICW2, icw4_required=0, cascade_mode=0.
REQ-038 reset_n low while write_enable_n low, release with write_enable_n high -> no strobe, all outputs at reset values.

Source files
------------

// File: rtl/command_word_sequencer_pkg.sv
// Shared types and bit positions for the command word sequencer.
// Decodes the A0 select and the ICW/OCW flag bits of a CPU write.
package command_word_sequencer_pkg;

  typedef enum logic [2:0] {
    StUninit,
    StWaitIcw2,
    StWaitIcw3,
    StWaitIcw4,
    StReady
  } seq_state_e;

  // A0 value that selects the command (ICW1/OCW2/OCW3) register
  localparam logic AddrCommand = 1'b0;

  localparam int unsigned BitIcw1Flag = 4;
  localparam int unsigned BitOcw3Flag = 3;
  localparam int unsigned BitSngl     = 1;
  localparam int unsigned BitIc4      = 0;

  localparam int unsigned NumStrobes = 7;
  localparam int unsigned StbIcw1    = 6;
  localparam int unsigned StbIcw2    = 5;
  localparam int unsigned StbIcw3    = 4;
  localparam int unsigned StbIcw4    = 3;
  localparam int unsigned StbOcw1    = 2;
  localparam int unsigned StbOcw2    = 1;
  localparam int unsigned StbOcw3    = 0;

endpackage

// File: rtl/write_event_detector.sv
// Captures selected CPU writes and flags the first cycle after the strobe
// is released, presenting the last captured address and data.
module write_event_detector (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       chip_select_n,
  input  logic       write_enable_n,
  input  logic       address,
  input  logic [7:0] data_bus_in,
  output logic       write_event,
  output logic       captured_address,
  output logic [7:0] captured_data
);

  logic       pending_q;
  logic       address_q;
  logic [7:0] data_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pending_q <= 1'b0;
      address_q <= 1'b0;
      data_q    <= 8'h00;
    end else if (!chip_select_n && !write_enable_n) begin
      pending_q <= 1'b1;
      address_q <= address;
      data_q    <= data_bus_in;
    end else if (write_enable_n) begin
      pending_q <= 1'b0;
    end
  end

  // Chip select is irrelevant once the strobe has been released
  assign write_event      = pending_q & write_enable_n;
  assign captured_address = address_q;
  assign captured_data    = data_q;

endmodule

// File: rtl/command_word_sequencer.sv
// Decodes completed CPU writes into ICW1-4 / OCW1-3 one-cycle strobes and
// tracks the initialization sequence.
module command_word_sequencer
  import command_word_sequencer_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       chip_select_n,
  input  logic       write_enable_n,
  input  logic       address,
  input  logic [7:0] data_bus_in,
  output logic [7:0] internal_data_bus,
  output logic       write_initial_command_word_1,
  output logic       write_initial_command_word_2,
  output logic       write_initial_command_word_3,
  output logic       write_initial_command_word_4,
  output logic       write_operation_control_word_1_registers,
  output logic       write_operation_control_word_2,
  output logic       write_operation_control_word_3,
  output logic       in_initialization,
  output logic       cascade_mode,
  output logic       icw4_required
);

  logic       write_event;
  logic       captured_address;
  logic [7:0] captured_data;

  seq_state_e            state_q, state_d;
  logic [NumStrobes-1:0] strobe_q, strobe_d;
  logic [7:0]            bus_q, bus_d;
  logic                  cascade_q, cascade_d;
  logic                  icw4_q, icw4_d;

  write_event_detector u_write_event_detector (
    .clock            (clock),
    .reset_n          (reset_n),
    .chip_select_n    (chip_select_n),
    .write_enable_n   (write_enable_n),
    .address          (address),
    .data_bus_in      (data_bus_in),
    .write_event      (write_event),
    .captured_address (captured_address),
    .captured_data    (captured_data)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= StUninit;
      strobe_q  <= '0;
      bus_q     <= 8'h00;
      cascade_q <= 1'b0;
      icw4_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      strobe_q  <= strobe_d;
      bus_q     <= bus_d;
      cascade_q <= cascade_d;
      icw4_q    <= icw4_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    strobe_d  = '0;
    bus_d     = bus_q;
    cascade_d = cascade_q;
    icw4_d    = icw4_q;
    if (write_event) begin
      bus_d = captured_data;
      // ICW1 restarts the sequence from any state
      if (captured_address == AddrCommand && captured_data[BitIcw1Flag]) begin
        strobe_d[StbIcw1] = 1'b1;
        cascade_d         = ~captured_data[BitSngl];
        icw4_d            = captured_data[BitIc4];
        state_d           = StWaitIcw2;
      end else begin
        case (state_q)
          StWaitIcw2: begin
            if (captured_address != AddrCommand) begin
              strobe_d[StbIcw2] = 1'b1;
              if (cascade_q)   state_d = StWaitIcw3;
              else if (icw4_q) state_d = StWaitIcw4;
              else             state_d = StReady;
            end
          end
          StWaitIcw3: begin
            if (captured_address != AddrCommand) begin
              strobe_d[StbIcw3] = 1'b1;
              state_d           = icw4_q ? StWaitIcw4 : StReady;
            end
          end
          StWaitIcw4: begin
            if (captured_address != AddrCommand) begin
              strobe_d[StbIcw4] = 1'b1;
              state_d           = StReady;
            end
          end
          StReady: begin
            if (captured_address != AddrCommand) strobe_d[StbOcw1] = 1'b1;
            else if (captured_data[BitOcw3Flag]) strobe_d[StbOcw3] = 1'b1;
            else                                 strobe_d[StbOcw2] = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign internal_data_bus                        = bus_q;
  assign write_initial_command_word_1             = strobe_q[StbIcw1];
  assign write_initial_command_word_2             = strobe_q[StbIcw2];
  assign write_initial_command_word_3             = strobe_q[StbIcw3];
  assign write_initial_command_word_4             = strobe_q[StbIcw4];
  assign write_operation_control_word_1_registers = strobe_q[StbOcw1];
  assign write_operation_control_word_2           = strobe_q[StbOcw2];
  assign write_operation_control_word_3           = strobe_q[StbOcw3];
  assign in_initialization = (state_q == StWaitIcw2) || (state_q == StWaitIcw3) ||
                             (state_q == StWaitIcw4);
  assign cascade_mode      = cascade_q;
  assign icw4_required     = icw4_q;

endmodule

// File: tb/tb_command_word_sequencer.sv
// Directed plus randomized bench for command_word_sequencer, checked against a
// queue-based model of the expected ICW sequence.
module tb_command_word_sequencer;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       chip_select_n = 1'b1;
  logic       write_enable_n = 1'b1;
  logic       address = 1'b0;
  logic [7:0] data_bus_in = 8'h00;
  logic [7:0] internal_data_bus;
  logic       icw1, icw2, icw3, icw4, ocw1, ocw2, ocw3;
  logic       in_initialization, cascade_mode, icw4_required;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: strobe vector order {ICW1..ICW4, OCW1..OCW3}
  bit         m_inited;
  int         m_pend[$];
  bit         m_casc, m_ic4;
  logic [7:0] m_bus;
  logic [6:0] m_strobe;

  command_word_sequencer dut (
    .clock                                    (clock),
    .reset_n                                  (reset_n),
    .chip_select_n                            (chip_select_n),
    .write_enable_n                           (write_enable_n),
    .address                                  (address),
    .data_bus_in                              (data_bus_in),
    .internal_data_bus                        (internal_data_bus),
    .write_initial_command_word_1             (icw1),
    .write_initial_command_word_2             (icw2),
    .write_initial_command_word_3             (icw3),
    .write_initial_command_word_4             (icw4),
    .write_operation_control_word_1_registers (ocw1),
    .write_operation_control_word_2           (ocw2),
    .write_operation_control_word_3           (ocw3),
    .in_initialization                        (in_initialization),
    .cascade_mode                             (cascade_mode),
    .icw4_required                            (icw4_required)
  );

  initial forever #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] dut_strobes();
    return {icw1, icw2, icw3, icw4, ocw1, ocw2, ocw3};
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".strobes"}, 32'(dut_strobes()), 32'(m_strobe));
    check({tag, ".bus"}, 32'(internal_data_bus), 32'(m_bus));
    check({tag, ".in_init"}, 32'(in_initialization), 32'(m_pend.size() > 0));
    check({tag, ".cascade"}, 32'(cascade_mode), 32'(m_casc));
    check({tag, ".icw4_req"}, 32'(icw4_required), 32'(m_ic4));
  endtask

  task automatic model_reset();
    m_inited = 1'b0;
    m_pend   = {};
    m_casc   = 1'b0;
    m_ic4    = 1'b0;
    m_bus    = 8'h00;
    m_strobe = '0;
  endtask

  task automatic model_write(input logic a, input logic [7:0] d);
    m_strobe = '0;
    m_bus    = d;
    if (a == 1'b0 && d[4]) begin
      m_strobe[6] = 1'b1;
      m_casc      = !d[1];
      m_ic4       = d[0];
      m_inited    = 1'b1;
      m_pend      = {2};
      if (m_casc) m_pend.push_back(3);
      if (m_ic4)  m_pend.push_back(4);
    end else if (m_pend.size() > 0) begin
      if (a == 1'b1) m_strobe[7 - m_pend.pop_front()] = 1'b1;
    end else if (m_inited) begin
      if (a == 1'b1)  m_strobe[2] = 1'b1;
      else if (d[3])  m_strobe[0] = 1'b1;
      else            m_strobe[1] = 1'b1;
    end
  endtask

  // Junk values in earlier low cycles check that the last capture wins.
  task automatic do_write(input string tag, input logic a, input logic [7:0] d);
    int n = $urandom_range(1, 2);
    for (int i = 0; i < n; i++) begin
      chip_select_n  = 1'b0;
      write_enable_n = 1'b0;
      if (i == n - 1) begin
        address     = a;
        data_bus_in = d;
      end else begin
        address     = 1'($urandom);
        data_bus_in = 8'($urandom);
      end
      tick();
    end
    write_enable_n = 1'b1;
    chip_select_n  = 1'($urandom);
    address        = 1'($urandom);
    data_bus_in    = 8'($urandom);
    check({tag, ".pre"}, 32'(dut_strobes()), 32'd0);
    tick();
    model_write(a, d);
    check_all(tag);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      chip_select_n  = 1'($urandom);
      write_enable_n = chip_select_n ? 1'($urandom) : 1'b1;
      address        = 1'($urandom);
      data_bus_in    = 8'($urandom);
      tick();
      m_strobe = '0;
      check_all("idle");
    end
    write_enable_n = 1'b1;
  endtask

  task automatic reset_mid_write();
    chip_select_n  = 1'b0;
    write_enable_n = 1'b0;
    address        = 1'b1;
    data_bus_in    = 8'hAA;
    tick();
    reset_n = 1'b0;
    tick();
    tick();
    model_reset();
    check_all("rst_hold");
    reset_n        = 1'b1;
    write_enable_n = 1'b1;
    chip_select_n  = 1'b1;
    tick();
    check_all("rst_rel1");
    tick();
    check_all("rst_rel2");
  endtask

  initial begin
    model_reset();
    tick();
    tick();
    check_all("reset");
    reset_n = 1'b1;
    tick();
    check_all("post_reset");

    do_write("uninit_a1", 1'b1, 8'hFF);
    do_write("uninit_a0", 1'b0, 8'h20);
    do_write("icw1_13", 1'b0, 8'h13);
    do_write("icw2_20", 1'b1, 8'h20);
    do_write("icw4_01", 1'b1, 8'h01);
    do_write("ocw1_0f", 1'b1, 8'h0F);
    do_write("ocw2_20", 1'b0, 8'h20);
    do_write("ocw3_08", 1'b0, 8'h08);
    do_write("icw1_10", 1'b0, 8'h10);
    do_write("ign_a0", 1'b0, 8'h05);
    do_write("icw2", 1'b1, 8'h40);
    do_write("icw3_04", 1'b1, 8'h04);
    do_write("ready_ocw1", 1'b1, 8'h55);
    do_write("icw1_11", 1'b0, 8'h11);
    do_write("icw2_b", 1'b1, 8'h28);
    do_write("icw1_12", 1'b0, 8'h12);
    check("restart.in_init", 32'(in_initialization), 32'd1);
    reset_mid_write();

    for (int k = 0; k < 300; k++) begin
      logic       a;
      logic [7:0] d;
      if ($urandom_range(0, 9) < 2) idle($urandom_range(1, 3));
      if (k == 150) reset_mid_write();
      a = ($urandom_range(0, 99) < 65) ? 1'b1 : 1'b0;
      d = 8'($urandom);
      do_write("rand", a, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
